adc_scan_ctrl: RTL and testbench
================================

Name: adc_scan_ctrl

Overview:
- Round-robin scheduler for the 4-channel I2C ADC driver.
- Paces conversions, selects the next enabled channel, and requests one conversion via a req/done handshake.
- Stores each channel's result in a packed 32-bit register that feeds the seg display path directly.
- Sits between top-level control and the ADC driver; replaces the driver's permanently asserted start.

Parameters:
- SYS_CLK, 50_000_000: system clock frequency in Hz.
- SCAN_HZ, 1_000: conversion request rate in Hz. TICK_DIV = SYS_CLK/SCAN_HZ cycles; must be ≥2.
- TIMEOUT_CYC, 200_000: maximum cycles to wait for adc_done; must be ≥1.

Ports:
- sys_clk, in, 1: system clock.
- sys_rst, in, 1: asynchronous active-low reset.
- scan_en, in, 1: enable scanning.
- ch_mask, in, 4: channel enable, bit n = channel n.
- adc_req, out, 1: conversion request to the ADC driver; held high until done or timeout.
- adc_ch, out, 2: channel for the current request; stable while adc_req=1.
- adc_done, in, 1: one-cycle completion pulse from the driver.
- adc_err, in, 1: qualifies adc_done; 1 = NACK/failed transfer.
- adc_data, in, 8: conversion result, valid when adc_done=1.
- ch_data, out, 32: packed results; channel n in bits [8n+7:8n].
- data_valid, out, 4: one-cycle pulse on bit n when ch_data slot n updates.
- err_cnt, out, 8: saturating count of failed and timed-out requests.
- busy, out, 1: high in SELECT, REQ, STORE, ERROR.

Behaviour:
- Reset (sys_rst=0, async):
  - adc_req=0, adc_ch=0, ch_data=0, data_valid=0, err_cnt=0, busy=0.
  - Channel pointer ptr=3, so the first pick is ch0. Tick counter=0. State=IDLE.
- IDLE:
  - Go to WAIT_TICK when scan_en=1 and ch_mask≠0.
- WAIT_TICK:
  - Tick counter is cleared on entry and counts up each cycle.
  - At count TICK_DIV-1, go to SELECT.
  - If scan_en=0, go to IDLE immediately; the counter clears.
- SELECT (1 cycle):
  - ch_mask is sampled here only.
  - Pick the first set bit scanning ptr+1, ptr+2, ... modulo 4; if only ptr's own bit is set, re-pick ptr.
  - Load ptr and adc_ch, then go to REQ.
  - If ch_mask=0, go to IDLE.
- REQ:
  - adc_req=1. The timeout counter starts at 0 on entry.
  - adc_done=1 and adc_err=0: capture adc_data, go to STORE.
  - adc_done=1 and adc_err=1: go to ERROR.
  - Timeout counter reaches TIMEOUT_CYC-1 with no done: go to ERROR; adc_req drops.
  - A done arriving in the same cycle as the timeout wins.
  - scan_en=0 does not abort REQ; the in-flight transaction always completes or times out.
- STORE (1 cycle):
  - ch_data slot ptr is written and data_valid[ptr]=1, one cycle after the adc_done sample.
  - All other slots are unchanged.
- ERROR (1 cycle):
  - err_cnt increments, saturating at 255.
  - ch_data is unchanged; no data_valid pulse.
- After STORE or ERROR:
  - Go to WAIT_TICK if scan_en=1, else IDLE.
  - ptr is kept, so the next scan resumes round-robin.
- General rules:
  - adc_done is ignored outside REQ.
  - adc_req deasserts the cycle after done is sampled.
  - Request period = TICK_DIV + transaction time + 2 cycles. Ticks are not accumulated or queued.
  - ch_mask changes take effect at the next SELECT only.
  - Reset mid-REQ: adc_req drops asynchronously. The driver must tolerate an abandoned request.

Test Plan:
- SYS_CLK=1000, SCAN_HZ=100 (TICK_DIV=10), ch_mask=4'b1111, scan_en=1; driver model answers done 5 cycles after req with data 8'h10+ch:
  - adc_ch sequence is 0,1,2,3,0.
  - ch_data=32'h13121110.
  - Exactly one data_valid pulse per slot update.
  - Consecutive adc_req rising edges are 10+5+3 cycles apart.
- ch_mask=4'b1010:
  - adc_ch alternates 1,3,1,3; slots 0 and 2 stay 8'h00.
  - Changing the mask to 4'b0100 mid-REQ lets the current request finish; the next adc_ch is 2.
- Driver returns adc_err=1 on ch2:
  - err_cnt 0→1; ch_data[23:16] keeps its prior value; no data_valid[2].
  - The next request is ch3.
- Driver never responds, TIMEOUT_CYC=20:
  - adc_req is high for exactly 20 cycles; err_cnt increments.
  - 300 timeouts leave err_cnt=255.
- Edge cases:
  - scan_en=0 during REQ: the request completes, STORE occurs, then IDLE with busy=0 and adc_req=0.
  - ch_mask=0 with scan_en=1: the block stays in IDLE.
- sys_rst asserted mid-REQ:
  - All outputs return to reset values asynchronously.
  - After release, the first request is ch0.

Source files
------------

// File: rtl/adc_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// Module   : adc_scan_ctrl_if
// Brief    : req/done handshake between the scan controller and ADC driver.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface adc_scan_ctrl_if;
  logic       adc_req;
  logic [1:0] adc_ch;
  logic       adc_done;
  logic       adc_err;
  logic [7:0] adc_data;

  modport master (
    output adc_req,
    output adc_ch,
    input  adc_done,
    input  adc_err,
    input  adc_data
  );

  modport slave (
    input  adc_req,
    input  adc_ch,
    output adc_done,
    output adc_err,
    output adc_data
  );
endinterface

`default_nettype wire

// File: rtl/adc_scan_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : adc_scan_ctrl
// Brief    : Round-robin 4-channel ADC conversion scheduler with result store.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module adc_scan_ctrl #(
  parameter int SYS_CLK     = 50_000_000,
  parameter int SCAN_HZ     = 1_000,
  parameter int TIMEOUT_CYC = 200_000
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   scan_en,
  input  logic [3:0]             ch_mask,
  adc_scan_ctrl_if.master        adc,
  output logic [31:0]            ch_data,
  output logic [3:0]             data_valid,
  output logic [7:0]             err_cnt,
  output logic                   busy
);

  localparam int TICK_DIV = SYS_CLK / SCAN_HZ;
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TO_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [TO_W-1:0]   C_TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_SELECT    = 3'd2,
    ST_REQ       = 3'd3,
    ST_STORE     = 3'd4,
    ST_ERROR     = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [TICK_W-1:0]   r_tick;
  logic [TO_W-1:0]     r_to;
  logic [1:0]          r_ptr;
  logic [1:0]          r_ch;
  logic [31:0]         r_data;
  logic [3:0]          r_valid;
  logic [7:0]          r_err;
  logic [1:0]          w_pick;
  logic                w_pick_found;
  logic [1:0]          w_idx;
  logic                w_done_ok;
  logic                w_done_bad;

  // Scan ptr+4 down to ptr+1 so the nearest set bit after ptr wins; ptr+4 == ptr.
  always_comb begin
    w_pick       = r_ptr;
    w_pick_found = 1'b0;
    w_idx        = r_ptr;
    for (int i = 4; i >= 1; i--) begin
      w_idx = r_ptr + 2'(i);
      if (ch_mask[w_idx]) begin
        w_pick       = w_idx;
        w_pick_found = 1'b1;
      end
    end
  end

  assign w_done_ok  = (r_state == ST_REQ) && adc.adc_done && !adc.adc_err;
  assign w_done_bad = (r_state == ST_REQ) && adc.adc_done &&  adc.adc_err;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (scan_en && (ch_mask != 4'b0000)) w_next = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (!scan_en)                   w_next = ST_IDLE;
        else if (r_tick == C_TICK_LAST) w_next = ST_SELECT;
      end
      ST_SELECT: begin
        w_next = w_pick_found ? ST_REQ : ST_IDLE;
      end
      ST_REQ: begin
        // A done in the timeout cycle takes priority over the timeout.
        if (w_done_ok)               w_next = ST_STORE;
        else if (w_done_bad)         w_next = ST_ERROR;
        else if (r_to == C_TO_LAST)  w_next = ST_ERROR;
      end
      ST_STORE, ST_ERROR: begin
        w_next = scan_en ? ST_WAIT_TICK : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state <= ST_IDLE;
      r_tick  <= '0;
      r_to    <= '0;
      r_ptr   <= 2'd3;
      r_ch    <= 2'd0;
      r_data  <= 32'h0;
      r_valid <= 4'h0;
      r_err   <= 8'h0;
    end else begin
      r_state <= w_next;
      r_tick  <= (r_state == ST_WAIT_TICK) ? r_tick + 1'b1 : '0;
      r_to    <= (r_state == ST_REQ) ? r_to + 1'b1 : '0;
      r_valid <= 4'h0;
      if ((r_state == ST_SELECT) && w_pick_found) begin
        r_ptr <= w_pick;
        r_ch  <= w_pick;
      end
      // Slot and its valid pulse become visible together during the STORE cycle.
      if (w_done_ok) begin
        r_data[{r_ptr, 3'b000} +: 8] <= adc.adc_data;
        r_valid[r_ptr]               <= 1'b1;
      end
      if ((r_state == ST_ERROR) && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end
    end
  end

  assign adc.adc_req = (r_state == ST_REQ);
  assign adc.adc_ch  = r_ch;
  assign ch_data     = r_data;
  assign data_valid  = r_valid;
  assign err_cnt     = r_err;
  assign busy        = (r_state == ST_SELECT) || (r_state == ST_REQ) ||
                       (r_state == ST_STORE)  || (r_state == ST_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : tb_adc_scan_ctrl
// Brief    : Directed self-checking bench for adc_scan_ctrl with a driver model.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_adc_scan_ctrl;

  logic        clk;
  logic        sys_rst;
  logic        scan_en;
  logic [3:0]  ch_mask;
  logic [31:0] ch_data;
  logic [3:0]  data_valid;
  logic [7:0]  err_cnt;
  logic        busy;

  adc_scan_ctrl_if bus();

  adc_scan_ctrl #(
    .SYS_CLK     (1000),
    .SCAN_HZ     (100),
    .TIMEOUT_CYC (20)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (sys_rst),
    .scan_en    (scan_en),
    .ch_mask    (ch_mask),
    .adc        (bus),
    .ch_data    (ch_data),
    .data_valid (data_valid),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int rise_cyc[$];
  int rise_ch[$];
  int hi_len[$];
  int hi_run   = 0;
  logic prev_req = 1'b0;
  int dv_cnt[4];
  int dv_total = 0;
  int dv_multi = 0;

  int drv_respond = 1;
  int drv_err_ch  = -1;
  int drv_cnt     = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Driver: done in the 6th REQ cycle, i.e. 5 cycles after adc_req rises.
  initial begin
    bus.adc_done = 1'b0;
    bus.adc_err  = 1'b0;
    bus.adc_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (bus.adc_req && (drv_respond != 0)) begin
        drv_cnt++;
        if (drv_cnt == 6) begin
          bus.adc_done = 1'b1;
          bus.adc_err  = (drv_err_ch == int'(bus.adc_ch));
          bus.adc_data = 8'h10 + {6'b0, bus.adc_ch};
        end else begin
          bus.adc_done = 1'b0;
          bus.adc_err  = 1'b0;
        end
      end else begin
        drv_cnt      = 0;
        bus.adc_done = 1'b0;
        bus.adc_err  = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.adc_req && !prev_req) begin
      rise_cyc.push_back(cyc);
      rise_ch.push_back(int'(bus.adc_ch));
    end
    if (bus.adc_req) hi_run++;
    else if (prev_req) begin
      hi_len.push_back(hi_run);
      hi_run = 0;
    end
    prev_req = bus.adc_req;
    for (int n = 0; n < 4; n++) dv_cnt[n] += int'(data_valid[n]);
    dv_total += $countones(data_valid);
    if ($countones(data_valid) > 1) dv_multi++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int evt_count(input int kind);
    if (kind == 0) return rise_ch.size();
    if (kind == 1) return hi_len.size();
    return dv_total;
  endfunction

  // kind 0: adc_req rises, 1: adc_req falls, 2: data_valid pulses
  task automatic wait_evt(input string tag, input int kind, input int n, input int budget);
    int c = 0;
    while ((evt_count(kind) < n) && (c < budget)) begin
      @(posedge clk);
      c++;
    end
    check_eq(tag, 32'(evt_count(kind) >= n), 32'd1);
    #1;
  endtask

  task automatic do_reset();
    sys_rst     = 1'b0;
    drv_respond = 1;
    drv_err_ch  = -1;
    repeat (3) @(posedge clk);
    rise_cyc.delete();
    rise_ch.delete();
    hi_len.delete();
    hi_run   = 0;
    prev_req = 1'b0;
    for (int n = 0; n < 4; n++) dv_cnt[n] = 0;
    dv_total = 0;
    dv_multi = 0;
    @(negedge clk);
    sys_rst = 1'b1;
  endtask

  initial begin
    logic [31:0] seq;
    sys_rst = 1'b0;
    scan_en = 1'b0;
    ch_mask = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req",   32'(bus.adc_req), 32'd0);
    check_eq("rst_ch",    32'(bus.adc_ch),  32'd0);
    check_eq("rst_data",  ch_data,          32'h0);
    check_eq("rst_valid", 32'(data_valid),  32'd0);
    check_eq("rst_err",   32'(err_cnt),     32'd0);
    check_eq("rst_busy",  32'(busy),        32'd0);

    // Empty mask keeps the block idle.
    scan_en = 1'b1;
    do_reset();
    repeat (30) @(posedge clk);
    #1;
    check_eq("mask0_rises", 32'(rise_ch.size()), 32'd0);
    check_eq("mask0_busy",  32'(busy),           32'd0);

    // Full mask round robin, period 10 + 5 + 3.
    ch_mask = 4'b1111;
    wait_evt("rr_rises", 0, 5, 200);
    seq = 32'h0;
    for (int i = 0; i < 5; i++) seq = (seq << 2) | 32'(rise_ch[i] & 3);
    check_eq("rr_ch_seq", seq, 32'h06C);
    for (int i = 0; i < 4; i++) check_eq("rr_period", 32'(rise_cyc[i+1] - rise_cyc[i]), 32'd18);
    check_eq("rr_data", ch_data, 32'h13121110);
    wait_evt("rr_dv", 2, 5, 40);
    check_eq("rr_dv0", 32'(dv_cnt[0]), 32'd2);
    check_eq("rr_dv1", 32'(dv_cnt[1]), 32'd1);
    check_eq("rr_dv2", 32'(dv_cnt[2]), 32'd1);
    check_eq("rr_dv3", 32'(dv_cnt[3]), 32'd1);
    check_eq("rr_dv_onehot", 32'(dv_multi), 32'd0);

    // Sparse mask, then a mid-REQ mask change.
    ch_mask = 4'b1010;
    do_reset();
    wait_evt("m1010_rises", 0, 4, 200);
    seq = 32'h0;
    for (int i = 0; i < 4; i++) seq = (seq << 2) | 32'(rise_ch[i] & 3);
    check_eq("m1010_ch_seq", seq, 32'h77);
    check_eq("m1010_data", ch_data, 32'h13001100);
    ch_mask = 4'b0100;
    wait_evt("m0100_rises", 0, 5, 100);
    check_eq("m0100_ch", 32'(rise_ch[4]), 32'd2);
    check_eq("m0100_dv3", 32'(dv_cnt[3]), 32'd2);

    // NACK on the second visit to ch2.
    ch_mask = 4'b1111;
    do_reset();
    wait_evt("err_rises5", 0, 5, 200);
    drv_err_ch = 2;
    wait_evt("err_rises8", 0, 8, 200);
    check_eq("err_next_ch", 32'(rise_ch[7]), 32'd3);
    check_eq("err_cnt1",    32'(err_cnt),    32'd1);
    check_eq("err_slot2",   32'(ch_data[23:16]), 32'h12);
    check_eq("err_dv2",     32'(dv_cnt[2]),  32'd1);

    // Silent driver: timeouts and saturation.
    ch_mask = 4'b0001;
    do_reset();
    drv_respond = 0;
    wait_evt("to_fall1", 1, 1, 100);
    check_eq("to_len", 32'(hi_len[0]), 32'd20);
    repeat (2) @(posedge clk);
    #1;
    check_eq("to_err1", 32'(err_cnt), 32'd1);
    wait_evt("to_fall300", 1, 300, 11000);
    check_eq("to_len300", 32'(hi_len[299]), 32'd20);
    repeat (40) @(posedge clk);
    #1;
    check_eq("to_sat", 32'(err_cnt), 32'd255);

    // scan_en dropped mid-REQ: request completes, then idle.
    ch_mask = 4'b0001;
    do_reset();
    wait_evt("off_rise", 0, 1, 100);
    scan_en = 1'b0;
    wait_evt("off_dv", 2, 1, 20);
    repeat (3) @(posedge clk);
    #1;
    check_eq("off_busy", 32'(busy),           32'd0);
    check_eq("off_req",  32'(bus.adc_req),    32'd0);
    check_eq("off_data", 32'(ch_data[7:0]),   32'h10);
    repeat (30) @(posedge clk);
    #1;
    check_eq("off_rises", 32'(rise_ch.size()), 32'd1);

    // Asynchronous reset in the middle of a request.
    scan_en = 1'b1;
    ch_mask = 4'b1111;
    do_reset();
    wait_evt("arst_rises", 0, 2, 100);
    #2;
    sys_rst = 1'b0;
    #1;
    check_eq("arst_req",   32'(bus.adc_req), 32'd0);
    check_eq("arst_ch",    32'(bus.adc_ch),  32'd0);
    check_eq("arst_data",  ch_data,          32'h0);
    check_eq("arst_valid", 32'(data_valid),  32'd0);
    check_eq("arst_err",   32'(err_cnt),     32'd0);
    check_eq("arst_busy",  32'(busy),        32'd0);
    do_reset();
    wait_evt("arst_rise1", 0, 1, 100);
    check_eq("arst_first_ch", 32'(rise_ch[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
